// File: rtl/rr_sel4_pkg.sv
// Shared definitions for the rr_sel4 round-robin select generator:
// state encoding, channel count and the one-hot grant decoder.
package rr_sel4_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Turns a channel index into the matching one-hot acknowledge vector.
    function automatic logic [N_REQ-1:0] onehot_dec(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority picker: returns the first requesting channel found when
// scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4), plus a flag saying any was found.
module rr_pick4
    import rr_sel4_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] pick,
    output logic             any
);

    // Walk offsets from farthest to nearest so the nearest hit is written last
    // and therefore wins; the 2-bit add wraps channel 3 back to channel 0.
    always_comb begin
        pick = ptr;
        any  = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[ptr + SEL_W'(i)]) begin
                pick = ptr + SEL_W'(i);
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_sel4.sv
// Round-robin select generator feeding a 4-input enable/select data mux.
// Grants one requester at a time for up to MAX_BURST accepted beats, then
// moves the priority pointer past it so every channel gets its turn.
// en/sel come straight from registers; gnt is the combinational per-beat
// acknowledge to the current owner.
module rr_sel4
    import rr_sel4_pkg::*;
#(
    parameter int MAX_BURST = 4     // legal range 1..255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             dst_ready,
    output logic             en,
    output logic [SEL_W-1:0] sel,
    output logic [N_REQ-1:0] gnt,
    output logic             busy
);

    localparam int               CNT_W     = 8;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    state_t             state_q;
    logic [SEL_W-1:0]   sel_q;
    logic [SEL_W-1:0]   ptr_q;
    logic [SEL_W-1:0]   ptr_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [SEL_W-1:0]   pick;
    logic               any;
    logic               owner_req;
    logic               xfer;

    rr_pick4 u_pick (
        .req  (req),
        .ptr  (ptr_q),
        .pick (pick),
        .any  (any)
    );

    // A beat moves only when the owner still requests and downstream accepts.
    assign owner_req = req[sel_q];
    assign xfer      = (state_q == GRANT) && dst_ready && owner_req;
    assign ptr_d     = sel_q + SEL_W'(1);
    assign cnt_d     = cnt_q + CNT_W'(1);

    // Arbitration FSM: IDLE picks a winner, GRANT counts beats until the burst
    // limit or a withdrawn request hands priority to the next channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any) begin
                        state_q <= GRANT;
                        sel_q   <= pick;
                        cnt_q   <= '0;
                    end
                end
                GRANT: begin
                    // A withdrawn request ends the grant even if downstream
                    // is ready; no beat is acknowledged in that cycle.
                    if (!owner_req) begin
                        state_q <= IDLE;
                        ptr_q   <= ptr_d;
                    end else if (dst_ready) begin
                        if (cnt_q == LAST_BEAT) begin
                            state_q <= IDLE;
                            ptr_q   <= ptr_d;
                        end else begin
                            cnt_q   <= cnt_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Mux controls are taken directly from the state registers.
    assign en   = (state_q == GRANT);
    assign busy = en;
    assign sel  = sel_q;
    assign gnt  = xfer ? onehot_dec(sel_q) : '0;

endmodule

// File: tb/tb_rr_sel4.sv
// Bench for rr_sel4: two instances (MAX_BURST=4 and MAX_BURST=1) share the
// same stimulus and are both tracked by a beat-counting reference model.
module tb_rr_sel4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b1111;
    logic       dst_ready = 1'b1;

    logic       en_w   [2];
    logic       busy_w [2];
    logic [1:0] sel_w  [2];
    logic [3:0] gnt_w  [2];

    always #5 clk = ~clk;

    rr_sel4 #(.MAX_BURST(4)) dut4 (
        .clk(clk), .rst(rst), .req(req), .dst_ready(dst_ready),
        .en(en_w[0]), .sel(sel_w[0]), .gnt(gnt_w[0]), .busy(busy_w[0])
    );

    rr_sel4 #(.MAX_BURST(1)) dut1 (
        .clk(clk), .rst(rst), .req(req), .dst_ready(dst_ready),
        .en(en_w[1]), .sel(sel_w[1]), .gnt(gnt_w[1]), .busy(busy_w[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Reference model: who owns the mux, how many beats it has moved, and
    // which channel gets first look at the next arbitration.
    int mb [2] = '{4, 1};
    bit m_valid = 1'b0;
    bit m_busy      [2];
    bit m_after_rst [2];
    int m_sel   [2];
    int m_ptr   [2];
    int m_beats [2];

    function automatic void model_check();
        if (!m_valid) return;
        for (int k = 0; k < 2; k++) begin
            logic [3:0] eg;
            eg = 4'b0000;
            if (m_busy[k] && dst_ready && req[m_sel[k]]) eg[m_sel[k]] = 1'b1;
            chk($sformatf("en[MB=%0d]", mb[k]),   32'(en_w[k]),   32'(m_busy[k]));
            chk($sformatf("busy[MB=%0d]", mb[k]), 32'(busy_w[k]), 32'(m_busy[k]));
            chk($sformatf("gnt[MB=%0d]", mb[k]),  32'(gnt_w[k]),  32'(eg));
            if (m_busy[k] || m_after_rst[k])
                chk($sformatf("sel[MB=%0d]", mb[k]), 32'(sel_w[k]), 32'(m_sel[k]));
        end
    endfunction

    function automatic void model_update();
        if (rst) begin
            m_valid = 1'b1;
            for (int k = 0; k < 2; k++) begin
                m_busy[k] = 1'b0; m_sel[k] = 0; m_ptr[k] = 0;
                m_beats[k] = 0;   m_after_rst[k] = 1'b1;
            end
            return;
        end
        if (!m_valid) return;
        for (int k = 0; k < 2; k++) begin
            m_after_rst[k] = 1'b0;
            if (!m_busy[k]) begin
                for (int o = 0; o < 4; o++) begin
                    int c;
                    c = (m_ptr[k] + o) % 4;
                    if (req[c]) begin
                        m_busy[k] = 1'b1; m_sel[k] = c; m_beats[k] = 0;
                        break;
                    end
                end
            end else if (!req[m_sel[k]]) begin
                m_busy[k] = 1'b0;
                m_ptr[k]  = (m_sel[k] + 1) % 4;
            end else if (dst_ready) begin
                m_beats[k]++;
                if (m_beats[k] == mb[k]) begin
                    m_busy[k] = 1'b0;
                    m_ptr[k]  = (m_sel[k] + 1) % 4;
                end
            end
        end
    endfunction

    task automatic sample(); @(negedge clk); model_check(); endtask
    task automatic adv();    @(posedge clk); model_update(); #1; endtask
    task automatic cyc();    sample(); adv(); endtask
    task automatic do_reset(); rst = 1'b1; cyc(); cyc(); rst = 1'b0; endtask

    typedef struct {
        bit         rst;
        logic [3:0] req;
        bit         dr;
        bit         chk;
        bit         csel;
        bit         en;
        logic [1:0] sel;
        logic [3:0] gnt;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   order[$];
        int   beats;
        bit   done;

        // Reset, release, then a MAX_BURST=4 burst on req=1010 from ptr=0.
        tbl[0]  = '{1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000};
        tbl[1]  = '{1'b1, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0000};
        tbl[2]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0000};
        tbl[3]  = '{1'b0, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 4'b0000};
        tbl[4]  = '{1'b1, 4'b1010, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 4'b0000};
        tbl[5]  = '{1'b0, 4'b1010, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0000};
        tbl[6]  = '{1'b0, 4'b1010, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 4'b0010};
        tbl[7]  = '{1'b0, 4'b1010, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 4'b0010};
        tbl[8]  = '{1'b0, 4'b1010, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 4'b0010};
        tbl[9]  = '{1'b0, 4'b1010, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 4'b0010};
        tbl[10] = '{1'b0, 4'b1010, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000};
        tbl[11] = '{1'b0, 4'b1010, 1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 4'b1000};

        for (int i = 0; i < 12; i++) begin
            rst = tbl[i].rst; req = tbl[i].req; dst_ready = tbl[i].dr;
            sample();
            if (tbl[i].chk) begin
                chk($sformatf("tbl%0d_en", i),  32'(en_w[0]),  32'(tbl[i].en));
                chk($sformatf("tbl%0d_gnt", i), 32'(gnt_w[0]), 32'(tbl[i].gnt));
                if (tbl[i].csel)
                    chk($sformatf("tbl%0d_sel", i), 32'(sel_w[0]), 32'(tbl[i].sel));
            end
            adv();
        end

        // Fairness with MAX_BURST=1: grants rotate 0,1,2,3,0 with bubbles.
        do_reset();
        req = 4'b1111; dst_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            sample();
            for (int j = 0; j < 4; j++) if (gnt_w[1][j] === 1'b1) order.push_back(j);
            adv();
        end
        chk("fair_count", 32'(order.size()), 32'd5);
        for (int j = 0; j < 5; j++)
            chk($sformatf("fair_order%0d", j),
                (j < order.size()) ? 32'(order[j]) : 32'hFFFF_FFFF, 32'(j % 4));

        // Backpressure after the 2nd beat; burst finishes with 2 more beats.
        do_reset();
        req = 4'b0001; dst_ready = 1'b1;
        cyc();
        sample(); chk("bp_beat1", 32'(gnt_w[0]), 32'b0001); adv();
        sample(); chk("bp_beat2", 32'(gnt_w[0]), 32'b0001); adv();
        dst_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            sample();
            chk("bp_hold_en",  32'(en_w[0]),  32'd1);
            chk("bp_hold_sel", 32'(sel_w[0]), 32'd0);
            chk("bp_hold_gnt", 32'(gnt_w[0]), 32'd0);
            adv();
        end
        dst_ready = 1'b1;
        beats = 0; done = 1'b0;
        for (int c = 0; c < 8 && !done; c++) begin
            sample();
            if (en_w[0] !== 1'b1) done = 1'b1;
            else if (gnt_w[0] === 4'b0001) beats++;
            adv();
        end
        chk("bp_end_seen", 32'(done), 32'd1);
        chk("bp_beats",    32'(beats), 32'd2);

        // Withdraw: owner 2 drops its request while downstream is ready.
        do_reset();
        req = 4'b0100; dst_ready = 1'b0;
        cyc();
        sample(); chk("wd_en", 32'(en_w[0]), 32'd1); chk("wd_sel", 32'(sel_w[0]), 32'd2); adv();
        req = 4'b1011; dst_ready = 1'b1;
        sample(); chk("wd_gnt", 32'(gnt_w[0]), 32'd0); adv();
        sample(); chk("wd_idle_en", 32'(en_w[0]), 32'd0); chk("wd_idle_gnt", 32'(gnt_w[0]), 32'd0); adv();
        sample(); chk("wd_next_en", 32'(en_w[0]), 32'd1); chk("wd_next_sel", 32'(sel_w[0]), 32'd3); adv();

        // Reset during the 3rd beat of a burst.
        do_reset();
        req = 4'b1100; dst_ready = 1'b1;
        cyc(); cyc(); cyc();
        rst = 1'b1;
        sample(); chk("mr_beat3", 32'(gnt_w[0]), 32'b0100); adv();
        rst = 1'b0; req = 4'b0110;
        sample(); chk("mr_en", 32'(en_w[0]), 32'd0); chk("mr_sel", 32'(sel_w[0]), 32'd0); adv();
        sample(); chk("mr_next_en", 32'(en_w[0]), 32'd1); chk("mr_next_sel", 32'(sel_w[0]), 32'd1); adv();

        // Randomised traffic: sticky requests, random backpressure, rare reset.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(3) == 0) req = 4'($urandom_range(15));
            dst_ready = ($urandom_range(3) != 0);
            rst = ($urandom_range(99) == 0);
            cyc();
        end
        rst = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
